// File: rtl/seq_alu.sv
// seq_alu -- handshaked WIDTH-bit ALU with registered result and status flags.
//
// Single-cycle ops (ADD, SUB, logic, shifts, compares) complete one cycle
// after the accept edge. MUL (shift-add) and DIVU/REMU (restoring division)
// iterate one bit per cycle and complete WIDTH+1 cycles after acceptance.
//
// Ports:
//   clk_i     clock, all state on rising edge
//   rstn_i    asynchronous active-low reset
//   a_i, b_i  operands (WIDTH bits); shift amount is b_i[$clog2(WIDTH)-1:0]
//   op_i      opcode: 0 ADD 1 SUB 2 AND 3 OR 4 XOR 5 NOR 6 SLL 7 SRL 8 SRA
//             9 SLT 10 SLTU 11 MUL 12 DIVU 13 REMU, 14-15 invalid
//   valid_i   request valid          ready_o  request can be accepted
//   result_o  registered result      zero_o   result_o == 0
//   carry_o   ADD carry / SUB no-borrow
//   ovf_o     ADD/SUB signed overflow
//   dbz_o     DIVU/REMU with b == 0  invalid  opcode 14 or 15
//   valid_o   result valid           ready_i  consumer accepts result
module seq_alu #(
  parameter int WIDTH = 8
) (
  input  logic             clk_i,
  input  logic             rstn_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic [3:0]       op_i,
  input  logic             valid_i,
  output logic             ready_o,
  output logic [WIDTH-1:0] result_o,
  output logic             zero_o,
  output logic             carry_o,
  output logic             ovf_o,
  output logic             dbz_o,
  output logic             invalid,
  output logic             valid_o,
  input  logic             ready_i
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);
  localparam logic [CW-1:0] CNT_ONE  = {{(CW-1){1'b0}}, 1'b1};

  localparam logic [3:0] OP_ADD  = 4'd0;
  localparam logic [3:0] OP_SUB  = 4'd1;
  localparam logic [3:0] OP_AND  = 4'd2;
  localparam logic [3:0] OP_OR   = 4'd3;
  localparam logic [3:0] OP_XOR  = 4'd4;
  localparam logic [3:0] OP_NOR  = 4'd5;
  localparam logic [3:0] OP_SLL  = 4'd6;
  localparam logic [3:0] OP_SRL  = 4'd7;
  localparam logic [3:0] OP_SRA  = 4'd8;
  localparam logic [3:0] OP_SLT  = 4'd9;
  localparam logic [3:0] OP_SLTU = 4'd10;
  localparam logic [3:0] OP_MUL  = 4'd11;
  localparam logic [3:0] OP_DIVU = 4'd12;
  localparam logic [3:0] OP_REMU = 4'd13;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           state_r, state_nx_s;
  logic [CW-1:0]    cnt_r;
  logic [3:0]       op_r;
  logic [WIDTH-1:0] a_r;      // MUL: multiplicand, shifted left each step
  logic [WIDTH-1:0] b_r;      // divisor (kept for dbz)
  logic [WIDTH-1:0] acc_r;    // MUL: partial product, DIV: partial remainder
  logic [WIDTH-1:0] quo_r;    // MUL: multiplier (shifts right), DIV: dividend->quotient

  logic             accept_s;
  logic             multi_s;
  logic [CW-1:0]    sh_s;
  logic [WIDTH:0]   sum_s;
  logic [WIDTH:0]   diff_s;
  logic [WIDTH-1:0] sc_res_s;
  logic             sc_carry_s;
  logic             sc_ovf_s;
  logic             sc_inv_s;

  logic [WIDTH-1:0] mul_acc_nx_s;
  logic [WIDTH:0]   div_sh_s;
  logic [WIDTH:0]   div_trial_s;
  logic [WIDTH-1:0] div_rem_nx_s;
  logic [WIDTH-1:0] div_quo_nx_s;
  logic [WIDTH-1:0] fin_res_s;

  // ready_o is held low during reset so nothing is accepted before release
  assign ready_o  = rstn_i & ((state_r == S_IDLE) | ((state_r == S_DONE) & ready_i));
  assign accept_s = valid_i & ready_o;
  assign multi_s  = (op_i == OP_MUL) | (op_i == OP_DIVU) | (op_i == OP_REMU);
  assign valid_o  = (state_r == S_DONE);
  assign sh_s     = b_i[CW-1:0];
  assign sum_s    = {1'b0, a_i} + {1'b0, b_i};
  assign diff_s   = {1'b0, a_i} - {1'b0, b_i};

  // Single-cycle result and flags, computed straight from the request inputs
  always_comb begin
    sc_res_s   = {WIDTH{1'b0}};
    sc_carry_s = 1'b0;
    sc_ovf_s   = 1'b0;
    sc_inv_s   = 1'b0;
    case (op_i)
      OP_ADD: begin
        sc_res_s   = sum_s[WIDTH-1:0];
        sc_carry_s = sum_s[WIDTH];
        sc_ovf_s   = (a_i[WIDTH-1] == b_i[WIDTH-1]) & (sum_s[WIDTH-1] != a_i[WIDTH-1]);
      end
      OP_SUB: begin
        sc_res_s   = diff_s[WIDTH-1:0];
        sc_carry_s = ~diff_s[WIDTH];
        sc_ovf_s   = (a_i[WIDTH-1] != b_i[WIDTH-1]) & (diff_s[WIDTH-1] != a_i[WIDTH-1]);
      end
      OP_AND:  sc_res_s = a_i & b_i;
      OP_OR:   sc_res_s = a_i | b_i;
      OP_XOR:  sc_res_s = a_i ^ b_i;
      OP_NOR:  sc_res_s = ~(a_i | b_i);
      OP_SLL:  sc_res_s = a_i << sh_s;
      OP_SRL:  sc_res_s = a_i >> sh_s;
      OP_SRA:  sc_res_s = $signed(a_i) >>> sh_s;
      OP_SLT:  sc_res_s = {{(WIDTH-1){1'b0}}, ($signed(a_i) < $signed(b_i))};
      OP_SLTU: sc_res_s = {{(WIDTH-1){1'b0}}, (a_i < b_i)};
      OP_MUL, OP_DIVU, OP_REMU: sc_res_s = {WIDTH{1'b0}};
      default: sc_inv_s = 1'b1;
    endcase
  end

  // One iteration of shift-add multiply and restoring divide
  always_comb begin
    if (quo_r[0]) begin
      mul_acc_nx_s = acc_r + a_r;
    end else begin
      mul_acc_nx_s = acc_r;
    end
    div_sh_s    = {acc_r, quo_r[WIDTH-1]};
    div_trial_s = div_sh_s - {1'b0, b_r};
    // No borrow means the divisor fits: keep the difference, quotient bit 1.
    // With b == 0 this always succeeds, giving all-ones quotient and rem = a.
    if (!div_trial_s[WIDTH]) begin
      div_rem_nx_s = div_trial_s[WIDTH-1:0];
      div_quo_nx_s = {quo_r[WIDTH-2:0], 1'b1};
    end else begin
      div_rem_nx_s = div_sh_s[WIDTH-1:0];
      div_quo_nx_s = {quo_r[WIDTH-2:0], 1'b0};
    end
    case (op_r)
      OP_MUL:  fin_res_s = mul_acc_nx_s;
      OP_DIVU: fin_res_s = div_quo_nx_s;
      default: fin_res_s = div_rem_nx_s;
    endcase
  end

  // FSM state register
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_r <= S_IDLE;
    end else begin
      state_r <= state_nx_s;
    end
  end

  // FSM next-state logic
  always_comb begin
    state_nx_s = state_r;
    case (state_r)
      S_IDLE, S_DONE: begin
        if (accept_s) begin
          if (multi_s) begin
            state_nx_s = S_BUSY;
          end else begin
            state_nx_s = S_DONE;
          end
        end else if ((state_r == S_DONE) && !ready_i) begin
          state_nx_s = S_DONE;
        end else begin
          state_nx_s = S_IDLE;
        end
      end
      S_BUSY: begin
        if (cnt_r == CNT_LAST) begin
          state_nx_s = S_DONE;
        end else begin
          state_nx_s = S_BUSY;
        end
      end
      default: state_nx_s = S_IDLE;
    endcase
  end

  // Operand capture, iteration datapath and registered result/flags
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      cnt_r    <= {CW{1'b0}};
      op_r     <= 4'd0;
      a_r      <= {WIDTH{1'b0}};
      b_r      <= {WIDTH{1'b0}};
      acc_r    <= {WIDTH{1'b0}};
      quo_r    <= {WIDTH{1'b0}};
      result_o <= {WIDTH{1'b0}};
      zero_o   <= 1'b0;
      carry_o  <= 1'b0;
      ovf_o    <= 1'b0;
      dbz_o    <= 1'b0;
      invalid  <= 1'b0;
    end else if (accept_s) begin
      op_r  <= op_i;
      a_r   <= a_i;
      b_r   <= b_i;
      cnt_r <= {CW{1'b0}};
      acc_r <= {WIDTH{1'b0}};
      if (op_i == OP_MUL) begin
        quo_r <= b_i;
      end else begin
        quo_r <= a_i;
      end
      if (!multi_s) begin
        result_o <= sc_res_s;
        zero_o   <= (sc_res_s == {WIDTH{1'b0}});
        carry_o  <= sc_carry_s;
        ovf_o    <= sc_ovf_s;
        dbz_o    <= 1'b0;
        invalid  <= sc_inv_s;
      end
    end else if (state_r == S_BUSY) begin
      cnt_r <= cnt_r + CNT_ONE;
      if (op_r == OP_MUL) begin
        acc_r <= mul_acc_nx_s;
        a_r   <= {a_r[WIDTH-2:0], 1'b0};
        quo_r <= {1'b0, quo_r[WIDTH-1:1]};
      end else begin
        acc_r <= div_rem_nx_s;
        quo_r <= div_quo_nx_s;
      end
      // Last iteration: the result goes straight from the step logic to the output
      if (cnt_r == CNT_LAST) begin
        result_o <= fin_res_s;
        zero_o   <= (fin_res_s == {WIDTH{1'b0}});
        carry_o  <= 1'b0;
        ovf_o    <= 1'b0;
        dbz_o    <= (op_r != OP_MUL) && (b_r == {WIDTH{1'b0}});
        invalid  <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_seq_alu.sv
// tb_seq_alu -- scoreboard bench for seq_alu (WIDTH=8).
// Expected results come from an arithmetic reference model; a monitor pops
// the queue whenever a result handshake occurs and checks value, flags and
// accept-to-valid latency.
module tb_seq_alu;
  localparam int W    = 8;
  localparam int MASK = (1 << W) - 1;
  localparam int HALF = 1 << (W - 1);

  logic         clk = 1'b0;
  logic         rstn_i;
  logic [W-1:0] a_i, b_i;
  logic [3:0]   op_i;
  logic         valid_i, ready_o;
  logic [W-1:0] result_o;
  logic         zero_o, carry_o, ovf_o, dbz_o, invalid, valid_o, ready_i;

  always #5 clk = ~clk;

  seq_alu #(.WIDTH(W)) dut (
    .clk_i(clk), .rstn_i(rstn_i), .a_i(a_i), .b_i(b_i), .op_i(op_i),
    .valid_i(valid_i), .ready_o(ready_o), .result_o(result_o),
    .zero_o(zero_o), .carry_o(carry_o), .ovf_o(ovf_o), .dbz_o(dbz_o),
    .invalid(invalid), .valid_o(valid_o), .ready_i(ready_i)
  );

  typedef struct {
    logic [W-1:0] res;
    logic [4:0]   flg;   // {zero, carry, ovf, dbz, invalid}
    int           acc;
    int           lat;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   tests = 0;
  int   fails = 0;
  int   cyc   = 0;
  bit   lat_done = 1'b0;
  bit   rnd_rdy  = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic timeout(input string nm);
    tests++;
    fails++;
    $display("FAIL %s: bound expired at cycle %0d", nm, cyc);
  endtask

  // Reference model: plain integer arithmetic on the operand values
  function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b, input logic [3:0] op);
    exp_t e;
    int ua, ub, sa, sbv, r, sh;
    bit c, v, d, inv;
    ua = int'(a); ub = int'(b);
    sa  = (ua >= HALF) ? ua - (1 << W) : ua;
    sbv = (ub >= HALF) ? ub - (1 << W) : ub;
    sh = ub % W;
    c = 0; v = 0; d = 0; inv = 0; e.lat = 1;
    case (op)
      4'd0:  begin r = ua + ub; c = (r > MASK); v = (sa + sbv > HALF - 1) || (sa + sbv < -HALF); end
      4'd1:  begin r = ua - ub; c = (ua >= ub); v = (sa - sbv > HALF - 1) || (sa - sbv < -HALF); end
      4'd2:  r = ua & ub;
      4'd3:  r = ua | ub;
      4'd4:  r = ua ^ ub;
      4'd5:  r = ~(ua | ub);
      4'd6:  r = ua << sh;
      4'd7:  r = ua >> sh;
      4'd8:  r = sa >>> sh;
      4'd9:  r = (sa < sbv) ? 1 : 0;
      4'd10: r = (ua < ub) ? 1 : 0;
      4'd11: begin r = ua * ub; e.lat = W + 1; end
      4'd12: begin r = (ub == 0) ? MASK : ua / ub; d = (ub == 0); e.lat = W + 1; end
      4'd13: begin r = (ub == 0) ? ua : ua % ub; d = (ub == 0); e.lat = W + 1; end
      default: begin r = 0; inv = 1; end
    endcase
    r = r & MASK;
    e.res = r[W-1:0];
    e.flg = {(r == 0), c, v, d, inv};
    e.acc = 0;
    return e;
  endfunction

  // Monitor: latency on first sight of each result, value/flags on handshake
  always begin
    @(negedge clk);
    #2;
    if (rstn_i && valid_o) begin
      if (sb.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_result: got 0x%0h with nothing outstanding", result_o);
      end else begin
        if (!lat_done) begin
          chk("latency", 32'(cyc - sb[0].acc + 1), 32'(sb[0].lat));
          lat_done = 1'b1;
        end
        if (ready_i) begin
          mon_e = sb.pop_front();
          chk("result", 32'(result_o), 32'(mon_e.res));
          chk("flags_zcvdi", 32'({zero_o, carry_o, ovf_o, dbz_o, invalid}), 32'(mon_e.flg));
          lat_done = 1'b0;
        end
      end
    end
  end

  task automatic rnd_ready();
    if (rnd_rdy) ready_i = ($urandom_range(0, 3) != 0);
  endtask

  task automatic send(input logic [W-1:0] a, input logic [W-1:0] b, input logic [3:0] op);
    int n;
    exp_t e;
    @(negedge clk);
    rnd_ready();
    a_i = a; b_i = b; op_i = op; valid_i = 1'b1;
    #1;
    n = 0;
    while (!ready_o && n < 200) begin
      @(negedge clk);
      rnd_ready();
      #1;
      n++;
    end
    if (!ready_o) begin
      timeout("accept");
      valid_i = 1'b0;
    end else begin
      @(posedge clk);
      #1;
      e = model(a, b, op);
      e.acc = cyc;
      sb.push_back(e);
      valid_i = 1'b0;
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 500) begin
      @(negedge clk);
      rnd_ready();
      n++;
    end
    if (sb.size() != 0) timeout("drain");
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [W-1:0] hold_res;
    logic [4:0]   hold_flg;
    int n;
    rstn_i = 1'b0; valid_i = 1'b0; ready_i = 1'b1;
    a_i = '0; b_i = '0; op_i = 4'd0;
    #1;
    chk("rst_ready_o", 32'(ready_o), 32'd0);
    chk("rst_valid_o", 32'(valid_o), 32'd0);
    chk("rst_result_o", 32'(result_o), 32'd0);
    chk("rst_flags", 32'({zero_o, carry_o, ovf_o, dbz_o, invalid}), 32'd0);
    repeat (2) @(negedge clk);
    rstn_i = 1'b1;
    #1;
    chk("post_rst_ready_o", 32'(ready_o), 32'd1);

    // ADD overflow, SUB to zero, then a back-to-back stream
    send(8'h7F, 8'h01, 4'd0);
    send(8'h05, 8'h05, 4'd1);
    send(8'hF0, 8'h3C, 4'd2);
    send(8'hA0, 8'h05, 4'd3);
    send(8'h80, 8'h03, 4'd8);
    send(8'h81, 8'h7F, 4'd9);
    send(8'h81, 8'h7F, 4'd10);
    drain();

    // MUL with an ignored request pulse while busy
    send(8'h0F, 8'h11, 4'd11);
    for (int i = 0; i < W; i++) begin
      @(negedge clk);
      if (i == 2) begin
        a_i = 8'h12; b_i = 8'h34; op_i = 4'd0; valid_i = 1'b1;
      end
      #1;
      chk("busy_ready_o", 32'(ready_o), 32'd0);
      valid_i = 1'b0;
    end
    drain();

    // Division, including divide by zero
    send(8'd200, 8'd7, 4'd12);
    send(8'd200, 8'd7, 4'd13);
    send(8'h2A, 8'h00, 4'd12);
    send(8'h2A, 8'h00, 4'd13);
    drain();

    // Invalid opcode under backpressure
    @(negedge clk);
    ready_i = 1'b0;
    send(8'h33, 8'h44, 4'd14);
    n = 0;
    while (!valid_o && n < 50) begin
      @(negedge clk);
      #1;
      n++;
    end
    if (!valid_o) timeout("bp_valid_wait");
    hold_res = result_o;
    hold_flg = {zero_o, carry_o, ovf_o, dbz_o, invalid};
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      #1;
      chk("bp_valid_o", 32'(valid_o), 32'd1);
      chk("bp_ready_o", 32'(ready_o), 32'd0);
      chk("bp_result_stable", 32'(result_o), 32'(hold_res));
      chk("bp_flags_stable", 32'({zero_o, carry_o, ovf_o, dbz_o, invalid}), 32'(hold_flg));
    end
    @(negedge clk);
    ready_i = 1'b1;
    #1;
    chk("bp_release_ready_o", 32'(ready_o), 32'd1);
    drain();

    // Randomized traffic with random consumer backpressure
    rnd_rdy = 1'b1;
    for (int i = 0; i < 80; i++) begin
      logic [W-1:0] ra, rb;
      ra = W'($urandom_range(0, MASK));
      rb = W'($urandom_range(0, MASK));
      if ($urandom_range(0, 7) == 0) rb = '0;
      send(ra, rb, 4'($urandom_range(0, 15)));
    end
    rnd_rdy = 1'b0;
    ready_i = 1'b1;
    drain();

    // Reset in the middle of a division
    send(8'h01, 8'h01, 4'd0);
    drain();
    send(8'd200, 8'd7, 4'd12);
    repeat (3) @(posedge clk);
    #2;
    rstn_i = 1'b0;
    #1;
    chk("midrst_valid_o", 32'(valid_o), 32'd0);
    chk("midrst_result_o", 32'(result_o), 32'd0);
    chk("midrst_ready_o", 32'(ready_o), 32'd0);
    sb.delete();
    @(negedge clk);
    rstn_i = 1'b1;
    #1;
    chk("rel_ready_o", 32'(ready_o), 32'd1);
    repeat (12) @(negedge clk);
    #1;
    chk("no_stale_valid_o", 32'(valid_o), 32'd0);
    send(8'd3, 8'd4, 4'd0);
    drain();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
